// File: rtl/div_quintuple.sv
// Sequential signed divide-by-5: restoring shift-subtract, one quotient bit per cycle.
// Undoes the x5 quintuplicator and flags exactness and operand-range fit of the quotient.
module div_quintuple #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-3:0] q,
    output logic [3:0]       r,
    output logic             exact,
    output logic             fits,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t             state, state_n;
    logic               sign, sign_n;
    logic [WIDTH-1:0]   mag, mag_n;
    logic [3:0]         rem, rem_n;
    logic [WIDTH-1:0]   qsh, qsh_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-3:0]   q_n;
    logic [3:0]         r_n;
    logic               exact_n, fits_n, busy_n, done_n;
    logic [3:0]         trial;
    logic [WIDTH-1:0]   qs;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sign  <= 1'b0;
            mag   <= '0;
            rem   <= '0;
            qsh   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            exact <= 1'b0;
            fits  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sign  <= sign_n;
            mag   <= mag_n;
            rem   <= rem_n;
            qsh   <= qsh_n;
            cnt   <= cnt_n;
            q     <= q_n;
            r     <= r_n;
            exact <= exact_n;
            fits  <= fits_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_n = state;
        sign_n  = sign;
        mag_n   = mag;
        rem_n   = rem;
        qsh_n   = qsh;
        cnt_n   = cnt;
        q_n     = q;
        r_n     = r;
        exact_n = exact;
        fits_n  = fits;
        done_n  = 1'b0;
        trial   = {rem[2:0], mag[WIDTH-1]};
        qs      = sign ? (-qsh) : qsh;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DIV;
                    sign_n  = y_in[WIDTH-1];
                    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
                    mag_n   = y_in[WIDTH-1] ? (-y_in) : y_in;
                    rem_n   = '0;
                    qsh_n   = '0;
                    cnt_n   = CNT_W'(WIDTH - 1);
                end
            end
            DIV: begin
                mag_n = {mag[WIDTH-2:0], 1'b0};
                if (trial >= 4'd5) begin
                    rem_n = trial - 4'd5;
                    qsh_n = {qsh[WIDTH-2:0], 1'b1};
                end else begin
                    rem_n = trial;
                    qsh_n = {qsh[WIDTH-2:0], 1'b0};
                end
                if (cnt == '0) begin
                    state_n = FIX;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            FIX: begin
                q_n     = qs[WIDTH-3:0];
                r_n     = sign ? (-rem) : rem;
                exact_n = (rem == 4'd0);
                // Quotient fits OP_W bits when all bits above the operand sign bit match it
                fits_n  = (qs[WIDTH-1:OP_W-1] == '0) || (qs[WIDTH-1:OP_W-1] == '1);
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_div_quintuple.sv
// Self-checking bench for div_quintuple: directed corner cases, round trip and random
// dividends compared against plain integer division.
module tb_div_quintuple;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [11:0] y_in;
    logic signed [9:0]  q;
    logic signed [3:0]  r;
    logic               exact, fits, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    div_quintuple #(.WIDTH(12), .OP_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .y_in  (y_in),
        .q     (q),
        .r     (r),
        .exact (exact),
        .fits  (fits),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_result(input int y);
        int eq, er;
        eq = y / 5;
        er = y % 5;
        check($sformatf("q(%0d)", y), int'(q), eq);
        check($sformatf("r(%0d)", y), int'(r), er);
        check($sformatf("exact(%0d)", y), int'(exact), int'(er == 0));
        check($sformatf("fits(%0d)", y), int'(fits), int'(eq >= -32 && eq <= 31));
    endtask

    // Called at a negedge: launches y, waits for DONE, checks latency, BUSY width and results.
    // Returns at the negedge where DONE is high. Optionally pulses a second START while busy.
    task automatic run_div(input int y, input int extra_at, input int extra_y);
        int n, busy_cnt;
        y_in  = 12'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (n == extra_at) begin
                y_in  = 12'(extra_y);
                start = 1'b1;
            end else begin
                start = 1'b0;
                y_in  = 12'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check($sformatf("latency(%0d)", y), n, 13);
        check($sformatf("busy_cycles(%0d)", y), busy_cnt, 13);
        check($sformatf("busy_at_done(%0d)", y), int'(busy), 0);
        check_result(y);
    endtask

    initial begin
        int v;
        int dcount;
        int directed[8] = '{15, -155, 160, -160, -2048, 2047, -7, 0};

        rst_n = 1'b0;
        start = 1'b0;
        y_in  = '0;
        #12;
        check("rst_q", int'(q), 0);
        check("rst_r", int'(r), 0);
        check("rst_flags", int'({exact, fits, busy, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corners, each followed by a check that DONE lasts one cycle
        foreach (directed[i]) begin
            run_div(directed[i], -1, 0);
            @(negedge clk);
            check($sformatf("done_pulse(%0d)", directed[i]), int'(done), 0);
        end

        // Round trip, back-to-back with START in each DONE cycle
        for (int a = -32; a <= 31; a++) begin
            run_div(a * 5, -1, 0);
        end
        @(negedge clk);

        // Random dividends, back-to-back
        for (int k = 0; k < 40; k++) begin
            v = int'($signed(12'($urandom)));
            run_div(v, -1, 0);
        end
        @(negedge clk);

        // START while busy is ignored
        run_div(25, 5, 50);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("busy_start_no_done", dcount, 0);
        check("busy_start_hold_q", int'(q), 5);
        check("busy_start_idle", int'(busy), 0);

        // Reset mid-operation aborts asynchronously
        y_in  = 12'(1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_q", int'(q), 0);
        check("abort_r", int'(r), 0);
        check("abort_flags", int'({exact, fits, busy, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("abort_no_done", dcount, 0);
        run_div(-3, -1, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
